pp_accum_bank: RTL and testbench
================================

Name: pp_accum_bank

Overview:
Multi-lane partial-product accumulator for the matrix multiplier datapath; it generalises the single partial-product and final-data registers.
- LANES independent lanes each sum DEPTH partial products with carry-in over a valid/ready stream.
- Each lane's sum is narrowed to DATA_WIDTH, with a per-lane invalid (overflow) flag.
- The final result is held under output back-pressure.
- Sits between the multiplier array and the result writeback.

Parameters:
DATA_WIDTH, 8, width of one final result element; partial products are 2*DATA_WIDTH.
LANES, 4, number of parallel accumulation lanes (>=1).
DEPTH, 4, partial products summed per result, i.e. matrix inner dimension (>=2).
SATURATE, 0, 0 = wrap (truncate low DATA_WIDTH bits); 1 = clamp to all-ones on overflow.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous abort; clears accumulators and counter.
in_valid  input  1  partial-product beat present.
in_ready  output  1  block accepts a beat this cycle.
in_pp  input  LANES*2*DATA_WIDTH  lane i at bits [i*2*DW +: 2*DW].
in_cin  input  LANES  per-lane carry-in added with in_pp.
out_valid  output  1  final result available.
out_ready  input  1  consumer takes result.
out_data  output  LANES*DATA_WIDTH  narrowed per-lane results.
out_invalid  output  LANES  per-lane overflow flag.
beat_cnt  output  clog2(DEPTH)  beats accepted toward current result (debug).

Behaviour:
- Reset (async, reset_n=0):
  - state=ACCUM, beat_cnt=0, accumulators=0.
  - out_valid=0, out_data=0, out_invalid=0, in_ready=1 after release.
- Accumulator width ACC_W = 2*DATA_WIDTH + clog2(DEPTH) + 1, unsigned; no accumulator overflow is possible for any legal input.
- Beat accepted when in_valid && in_ready.
- State ACCUM (in_ready=1, out_valid=0):
  - On each accepted beat: acc[i] <= acc[i] + in_pp[i] + in_cin[i]; beat_cnt increments.
  - First beat of a result (beat_cnt==0) loads acc[i] <= in_pp[i] + in_cin[i]; old contents are ignored.
  - Accepted beat with beat_cnt==DEPTH-1: register the final values, go to DONE, beat_cnt <= 0.
    - out_invalid[i] = |final[ACC_W-1:DATA_WIDTH].
    - out_data[i] = final[DATA_WIDTH-1:0], or all-ones if SATURATE && out_invalid[i].
- State DONE (in_ready=0, out_valid=1):
  - out_data and out_invalid are held stable until out_ready.
  - On out_ready: out_valid <= 0, return to ACCUM.
  - No beat is accepted in the handshake cycle; the next beat is accepted the following cycle.
- Latency: out_valid asserts the cycle after the last beat is accepted.
- Throughput: one result per DEPTH+1 cycles with out_ready tied high.
- in_valid=0 cycles in ACCUM: accumulators and beat_cnt hold (gaps allowed).
- clr (sync, highest priority over all else):
  - beat_cnt <= 0, state <= ACCUM, out_valid <= 0.
  - out_data and out_invalid keep their last values.
  - A beat presented in the clr cycle is dropped.
- Reset mid-accumulation or in DONE: everything returns to reset values; the pending result is lost.
- Outputs are registered; no combinational path from in_* to out_*. in_ready depends on state only.

Decomposition:
- Shared package/header mm_pkg: DATA_WIDTH default, the ACC_W function, the clog2 helper, state encodings ACCUM=1'b0, DONE=1'b1.
- One natural sub-module, pp_accum_lane: one accumulator plus narrowing/saturate logic, replicated LANES times by generate.
- The top level holds the FSM, beat counter and handshake.

Test Plan:
All cases use DATA_WIDTH=8, LANES=2, DEPTH=3, SATURATE=0 unless stated.
1. Reset mid-run: hold reset_n=0 after 1 beat -> out_valid=0, out_data=0, out_invalid=0, beat_cnt=0; after release, in_ready=1.
2. Basic sum: lane0 pp 10,20,30, cin 0; lane1 pp 1,1,1, cin 1,1,1 -> cycle after 3rd beat: out_valid=1, lane0=60 inv0, lane1=6 inv0.
3. Overflow: lane1 pp 200,100,0, cin 0,0,1 -> sum 301, out_data=45 inv1; with SATURATE=1 -> out_data=255 inv1.
4. Back-pressure and gaps:
   - out_ready=0 for 5 cycles after result -> out_valid, out_data stable, in_ready=0, no beat consumed.
   - out_ready=1 -> next result accumulates from zero.
   - Insert in_valid gaps between beats -> same 60 result.
5. Extremes: all lanes pp 16'hFFFF x3, cin 1 each -> acc 0x30000 with no accumulator overflow; out_data=0x00, inv1 (SATURATE=1: 0xFF).
6. Abort: clr after 2 beats (pp 50,50), then beats 1,2,3 -> result 6, not 106; a clr in DONE drops out_valid next cycle.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiplier datapath: widths, the
// accumulator sizing rule and the accumulate/hold state encoding.
package mm_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Wide enough that DEPTH beats of full-scale products plus carries never wrap.
  function automatic int acc_w(input int data_width, input int depth);
    return 2 * data_width + clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pp_accum_lane.sv
// One accumulation lane: sums partial products plus carry-in and registers
// the narrowed (wrapped or clamped) result with its overflow flag.
module pp_accum_lane
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_W      = acc_w(DATA_WIDTH_DEF, 4),
  parameter int SATURATE   = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    accept,
  input  logic                    first,
  input  logic                    last,
  input  logic [2*DATA_WIDTH-1:0] pp,
  input  logic                    cin,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_invalid
);

  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      base;
  logic [ACC_W-1:0]      sum;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] narrowed;

  // The first beat of a result ignores whatever the accumulator held.
  always_comb begin
    base     = first ? '0 : acc;
    sum      = base + ACC_W'(pp) + ACC_W'(cin);
    ovf      = |sum[ACC_W-1:DATA_WIDTH];
    narrowed = ((SATURATE != 0) && ovf) ? '1 : sum[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      out_data    <= '0;
      out_invalid <= 1'b0;
    end else if (clr) begin
      acc <= '0;
    end else if (accept) begin
      acc <= sum;
      if (last) begin
        out_data    <= narrowed;
        out_invalid <= ovf;
      end
    end
  end

endmodule

// File: rtl/pp_accum_bank.sv
// Multi-lane partial-product accumulator: LANES lanes each sum DEPTH beats,
// then the narrowed results are held until the consumer takes them.
module pp_accum_bank
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = 4,
  parameter int DEPTH      = 4,
  parameter int SATURATE   = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*2*DATA_WIDTH-1:0] in_pp,
  input  logic [LANES-1:0]              in_cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [LANES-1:0]              out_invalid,
  output logic [clog2(DEPTH)-1:0]       beat_cnt,
  output logic                          fsm_state
);

  localparam int CW    = clog2(DEPTH);
  localparam int ACC_W = acc_w(DATA_WIDTH, DEPTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(DEPTH - 1);

  state_t state;
  logic   accept;
  logic   first;
  logic   last;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends on state alone; out_valid/out_data only change once
  // taken (out_ready) or aborted (clr). A beat offered during clr is dropped.
  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid && in_ready && !clr;
  assign first     = (beat_cnt == '0);
  assign last      = (beat_cnt == LAST_BEAT);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ACCUM;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= ACCUM;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              beat_cnt  <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pp_accum_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_W     (ACC_W),
      .SATURATE  (SATURATE)
    ) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (clr),
      .accept     (accept),
      .first      (first),
      .last       (last),
      .pp         (in_pp[i*2*DATA_WIDTH +: 2*DATA_WIDTH]),
      .cin        (in_cin[i]),
      .out_data   (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .out_invalid(out_invalid[i])
    );
  end

endmodule

// File: tb/tb_pp_accum_bank.sv
// Bench for pp_accum_bank: wrap and saturate instances share one stimulus
// stream and are checked against an integer-arithmetic reference every cycle.
module tb_pp_accum_bank;

  localparam int DW    = 8;
  localparam int L     = 2;
  localparam int DEPTH = 3;
  localparam int CW    = 2;
  localparam int SBW   = L + 2 * L * DW;

  logic              clk;
  logic              reset_n;
  logic              clr;
  logic              in_valid;
  logic [L*2*DW-1:0] in_pp;
  logic [L-1:0]      in_cin;
  logic              out_ready;

  logic              in_ready,    in_ready_s;
  logic              out_valid,   out_valid_s;
  logic [L*DW-1:0]   out_data,    out_data_s;
  logic [L-1:0]      out_invalid, out_invalid_s;
  logic [CW-1:0]     beat_cnt,    beat_cnt_s;
  logic              fsm_state,   fsm_state_s;

  int n_checks;
  int n_errors;

  // reference model state
  bit              m_done;
  int              m_cnt;
  int              m_sum[L];
  logic [L*DW-1:0] m_data;
  logic [L*DW-1:0] m_sdata;
  logic [L-1:0]    m_inv;
  logic [SBW-1:0]  exp_q[$];

  pp_accum_bank #(.DATA_WIDTH(DW), .LANES(L), .DEPTH(DEPTH), .SATURATE(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_pp(in_pp), .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_invalid(out_invalid), .beat_cnt(beat_cnt), .fsm_state(fsm_state)
  );

  pp_accum_bank #(.DATA_WIDTH(DW), .LANES(L), .DEPTH(DEPTH), .SATURATE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_pp(in_pp), .in_cin(in_cin), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_invalid(out_invalid_s), .beat_cnt(beat_cnt_s),
    .fsm_state(fsm_state_s)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, n_errors=%0d n_checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain integer sums, evaluated at each rising edge
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_done  = 1'b0;
        m_cnt   = 0;
        m_data  = '0;
        m_sdata = '0;
        m_inv   = '0;
        for (int l = 0; l < L; l++) m_sum[l] = 0;
        exp_q.delete();
      end else if (clr) begin
        m_done = 1'b0;
        m_cnt  = 0;
      end else if (!m_done) begin
        if (in_valid) begin
          for (int l = 0; l < L; l++) begin
            if (m_cnt == 0) m_sum[l] = 0;
            m_sum[l] = m_sum[l] + int'(in_pp[l*2*DW +: 2*DW]) + int'(in_cin[l]);
          end
          m_cnt++;
          if (m_cnt == DEPTH) begin
            m_cnt  = 0;
            m_done = 1'b1;
            for (int l = 0; l < L; l++) begin
              int d;
              d = m_sum[l] % 256;
              m_inv[l]              = (m_sum[l] > 255);
              m_data[l*DW +: DW]    = d[DW-1:0];
              m_sdata[l*DW +: DW]   = (m_sum[l] > 255) ? 8'hFF : d[DW-1:0];
            end
            exp_q.push_back({m_inv, m_data, m_sdata});
          end
        end
      end else if (out_ready) begin
        m_done = 1'b0;
      end
    end
  end

  // compare process: every falling edge, both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      check("in_ready",      in_ready,      !m_done);
      check("out_valid",     out_valid,     m_done);
      check("beat_cnt",      beat_cnt,      m_cnt);
      check("out_data",      out_data,      m_data);
      check("out_invalid",   out_invalid,   m_inv);
      check("in_ready_s",    in_ready_s,    !m_done);
      check("out_valid_s",   out_valid_s,   m_done);
      check("beat_cnt_s",    beat_cnt_s,    m_cnt);
      check("out_data_s",    out_data_s,    m_sdata);
      check("out_invalid_s", out_invalid_s, m_inv);
      if (reset_n && m_done && clr) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (reset_n && m_done && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 0, 1);
        end else begin
          check("sb_result", {out_invalid, out_data, out_data_s}, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic beat(input logic [15:0] p0, input logic [15:0] p1, input logic [1:0] c);
    in_pp    = {p1, p0};
    in_cin   = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_pp     = '0;
    in_cin    = '0;
    out_ready = 1'b0;
    idle(3);
    reset_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    // basic sum
    beat(16'd10, 16'd1, 2'b10);
    beat(16'd20, 16'd1, 2'b10);
    beat(16'd30, 16'd1, 2'b10);
    check("basic_valid", out_valid, 1);
    check("basic_data", out_data, 16'h063C);
    check("basic_inv", out_invalid, 2'b00);
    check("basic_sat_data", out_data_s, 16'h063C);
    check("basic_in_ready", in_ready, 0);
    take();
    check("basic_taken_valid", out_valid, 0);
    check("basic_taken_ready", in_ready, 1);

    // overflow on lane 1: 200+100+0+1 = 301
    beat(16'd0, 16'd200, 2'b00);
    beat(16'd0, 16'd100, 2'b00);
    beat(16'd0, 16'd0,   2'b10);
    check("ovf_data", out_data, 16'h2D00);
    check("ovf_inv", out_invalid, 2'b10);
    check("ovf_sat_data", out_data_s, 16'hFF00);
    check("ovf_sat_inv", out_invalid_s, 2'b10);

    // back-pressure with beats offered while holding
    in_pp    = {16'd99, 16'd99};
    in_cin   = 2'b11;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, 16'h2D00);
      check("hold_in_ready", in_ready, 0);
      check("hold_beat_cnt", beat_cnt, 0);
    end
    in_valid = 1'b0;
    take();

    // gaps between beats
    beat(16'd10, 16'd0, 2'b00);
    idle(2);
    beat(16'd20, 16'd0, 2'b00);
    idle(3);
    check("gap_beat_cnt", beat_cnt, 2);
    beat(16'd30, 16'd0, 2'b00);
    check("gap_data", out_data, 16'h003C);
    check("gap_inv", out_invalid, 2'b00);
    take();

    // extremes: 3*0xFFFF + 3 = 0x30000
    for (int k = 0; k < 3; k++) beat(16'hFFFF, 16'hFFFF, 2'b11);
    check("ext_data", out_data, 16'h0000);
    check("ext_inv", out_invalid, 2'b11);
    check("ext_sat_data", out_data_s, 16'hFFFF);
    take();

    // abort mid-accumulation, beat in the clr cycle dropped
    beat(16'd50, 16'd50, 2'b00);
    beat(16'd50, 16'd50, 2'b00);
    check("abort_pre_cnt", beat_cnt, 2);
    clr      = 1'b1;
    in_pp    = {16'd77, 16'd77};
    in_valid = 1'b1;
    idle(1);
    clr      = 1'b0;
    in_valid = 1'b0;
    check("abort_cnt", beat_cnt, 0);
    check("abort_keep_data", out_data, 16'h0000);
    check("abort_keep_inv", out_invalid, 2'b11);
    beat(16'd1, 16'd1, 2'b00);
    beat(16'd2, 16'd2, 2'b00);
    beat(16'd3, 16'd3, 2'b00);
    check("abort_result", out_data, 16'h0606);
    check("abort_result_inv", out_invalid, 2'b00);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("clr_done_valid", out_valid, 0);
    check("clr_done_ready", in_ready, 1);
    check("clr_done_data", out_data, 16'h0606);

    // reset mid-run
    beat(16'd7, 16'd7, 2'b00);
    check("mid_cnt", beat_cnt, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_inv", out_invalid, 0);
    check("mid_rst_cnt", beat_cnt, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("mid_rst_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) beat(16'd1, 16'd1, 2'b00);
    check("post_rst_data", out_data, 16'h0303);
    take();

    idle(2);
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
